// File: rtl/vliw_fetch_pkg.sv
// Shared types for the VLIW instruction fetch path.
//   bundle_t      : one 128-bit instruction bundle (4 x 32-bit slots)
//   fetch_entry_t : {pc, bundle} pair held by the prefetch queue
//   PC_STEP       : byte distance between sequential bundles
//   NOP_BUNDLE    : value presented on the bundle output when nothing is valid
package vliw_fetch_pkg;

    typedef logic [127:0] bundle_t;

    typedef struct packed {
        logic [31:0] pc;
        bundle_t     bundle;
    } fetch_entry_t;

    localparam int unsigned PC_STEP    = 16;
    localparam bundle_t     NOP_BUNDLE = '0;

endpackage

// File: rtl/bpq_storage.sv
// Circular buffer of fetch entries for the bundle prefetch queue.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (pointers and count)
//   clear          : empties the buffer at the next edge; wins over push/pop
//   push, push_entry : write push_entry at the tail
//   pop            : retire the head entry
//   head_entry     : entry at the head (meaningful only when count != 0)
//   count          : number of entries held
// The caller guarantees no push when full and no pop when empty.
module bpq_storage
    import vliw_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output fetch_entry_t             head_entry,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = push_entry;
                tail_d        = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_entry = mem_q[head_q];
    assign count      = count_q;

endmodule

// File: rtl/bundle_prefetch_queue.sv
// Bundle prefetch queue between main_memory's instruction port and instruction_fetch.
// Issues sequential bundle reads ahead of decode, buffers up to DEPTH {pc, bundle}
// entries and presents the head with a valid/ready handshake. A flush squashes the
// queue and redirects fetch to flush_pc.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   mem_req_valid, mem_req_pc       : bundle read request (memory always accepts)
//   mem_rsp_valid, mem_rsp_bundle   : response, one cycle after the request
//   data_start_addr                 : fetch stops once fetch_pc reaches this address
//   flush, flush_pc                 : branch-taken squash and redirect target
//   out_valid, out_pc, out_bundle   : head entry towards instruction_fetch
//   out_ready                       : consumer takes the head this cycle
//   occupancy                       : entries held
//   fetch_done                      : boundary reached, queue empty, nothing in flight
// Optional build macro BPQ_STATS_EN adds stat_empty_cycles and stat_flushes
// (saturating 32-bit counters).
module bundle_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          BUNDLE_W = 128,
    parameter int unsigned PC_STEP  = vliw_fetch_pkg::PC_STEP,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      mem_req_valid,
    output logic [31:0]               mem_req_pc,
    input  logic                      mem_rsp_valid,
    input  logic [BUNDLE_W-1:0]       mem_rsp_bundle,
    input  logic [31:0]               data_start_addr,
    input  logic                      flush,
    input  logic [31:0]               flush_pc,
    output logic                      out_valid,
    output logic [31:0]               out_pc,
    output logic [BUNDLE_W-1:0]       out_bundle,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      fetch_done
`ifdef BPQ_STATS_EN
    ,
    output logic [31:0]               stat_empty_cycles,
    output logic [31:0]               stat_flushes
`endif
);

    import vliw_fetch_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   credit_used;
    fetch_entry_t     head_entry;
    fetch_entry_t     push_entry;
    logic             push, pop, q_empty, below_bound, has_credit;

    bpq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (count)
    );

    always_comb begin
        below_bound = fetch_pc_q < data_start_addr;
        // An outstanding request reserves a slot, so its response always fits.
        credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
        has_credit  = credit_used < (CNT_W+1)'(DEPTH);
        q_empty     = (count == '0);

        mem_req_valid = !rst && !flush && below_bound && has_credit;
        mem_req_pc    = fetch_pc_q;

        out_valid  = !rst && !q_empty;
        out_pc     = out_valid ? head_entry.pc : 32'h0;
        out_bundle = out_valid ? BUNDLE_W'(head_entry.bundle) : BUNDLE_W'(NOP_BUNDLE);
        occupancy  = rst ? '0 : count;
        fetch_done = !rst && !below_bound && q_empty && !inflight_q;

        // Responses with no matching request, or landing in the flush cycle, are dropped.
        push       = !rst && !flush && mem_rsp_valid && inflight_q;
        pop        = !rst && !flush && out_valid && out_ready;
        push_entry = '{pc: inflight_pc_q, bundle: bundle_t'(mem_rsp_bundle)};

        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        if (flush) begin
            fetch_pc_d = flush_pc;
            inflight_d = 1'b0;
        end else if (mem_req_valid) begin
            fetch_pc_d    = fetch_pc_q + 32'(PC_STEP);
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
        end else if (push) begin
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

`ifdef BPQ_STATS_EN
    logic [31:0] stat_empty_cycles_q, stat_empty_cycles_d;
    logic [31:0] stat_flushes_q, stat_flushes_d;

    always_comb begin
        stat_empty_cycles_d = stat_empty_cycles_q;
        stat_flushes_d      = stat_flushes_q;
        if (q_empty && !fetch_done && stat_empty_cycles_q != 32'hFFFF_FFFF) begin
            stat_empty_cycles_d = stat_empty_cycles_q + 32'h1;
        end
        if (flush && stat_flushes_q != 32'hFFFF_FFFF) begin
            stat_flushes_d = stat_flushes_q + 32'h1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_empty_cycles_q <= 32'h0;
            stat_flushes_q      <= 32'h0;
        end else begin
            stat_empty_cycles_q <= stat_empty_cycles_d;
            stat_flushes_q      <= stat_flushes_d;
        end
    end

    assign stat_empty_cycles = stat_empty_cycles_q;
    assign stat_flushes      = stat_flushes_q;
`endif

endmodule

// File: tb/tb_bundle_prefetch_queue.sv
// Self-checking bench for bundle_prefetch_queue. The bench acts as main memory
// (answers every request one cycle later, occasionally strobes a stray response)
// and predicts every output from a queue-based reference model.
module tb_bundle_prefetch_queue;

    localparam int DEPTH = 4;
    localparam int BW    = 128;

    logic            clk;
    logic            rst;
    logic            mem_req_valid;
    logic [31:0]     mem_req_pc;
    logic            mem_rsp_valid;
    logic [BW-1:0]   mem_rsp_bundle;
    logic [31:0]     data_start_addr;
    logic            flush;
    logic [31:0]     flush_pc;
    logic            out_valid;
    logic [31:0]     out_pc;
    logic [BW-1:0]   out_bundle;
    logic            out_ready;
    logic [2:0]      occupancy;
    logic            fetch_done;
`ifdef BPQ_STATS_EN
    logic [31:0]     stat_empty_cycles;
    logic [31:0]     stat_flushes;
`endif

    bundle_prefetch_queue #(.DEPTH(DEPTH), .BUNDLE_W(BW)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req_valid   (mem_req_valid),
        .mem_req_pc      (mem_req_pc),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_bundle  (mem_rsp_bundle),
        .data_start_addr (data_start_addr),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_bundle      (out_bundle),
        .out_ready       (out_ready),
        .occupancy       (occupancy),
        .fetch_done      (fetch_done)
`ifdef BPQ_STATS_EN
        ,
        .stat_empty_cycles (stat_empty_cycles),
        .stat_flushes      (stat_flushes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   pc;
        logic [BW-1:0] bundle;
    } ent_t;

    ent_t          mq[$];
    logic [31:0]   m_fetch_pc;
    bit            m_pend;
    logic [31:0]   m_pend_pc;
    logic [31:0]   m_empty_cnt;
    logic [31:0]   m_flush_cnt;
    logic [31:0]   dsa_next;
    bit            last_req;
    logic [31:0]   last_pc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] bundle_of(input logic [31:0] pc);
        return {pc ^ 32'hC0DE_0000, ~pc, pc + 32'h1234_5678, pc[15:0], pc[31:16]};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_fetch_pc  = 32'h0;
        m_pend      = 1'b0;
        m_pend_pc   = 32'h0;
        m_empty_cnt = 32'h0;
        m_flush_cnt = 32'h0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check, advance the model.
    task automatic step(input bit r, input bit rdy, input bit fl, input logic [31:0] fpc);
        bit            ex_req, ex_valid, ex_done;
        logic [31:0]   ex_pc;
        logic [BW-1:0] ex_bundle;
        logic [2:0]    ex_occ;
        ent_t          e;

        @(negedge clk);
        rst             = r;
        out_ready       = rdy;
        flush           = fl;
        flush_pc        = fpc;
        data_start_addr = dsa_next;
        if (last_req) begin
            mem_rsp_valid  = 1'b1;
            mem_rsp_bundle = bundle_of(last_pc);
        end else if ($urandom_range(0, 7) == 0) begin
            mem_rsp_valid  = 1'b1;
            mem_rsp_bundle = {$urandom, $urandom, $urandom, $urandom};
        end else begin
            mem_rsp_valid  = 1'b0;
            mem_rsp_bundle = '0;
        end
        #1;

        if (r) begin
            ex_req = 0; ex_valid = 0; ex_done = 0;
            ex_pc = '0; ex_bundle = '0; ex_occ = '0;
        end else begin
            ex_req    = !fl && (m_fetch_pc < dsa_next) && (mq.size() + int'(m_pend) < DEPTH);
            ex_valid  = mq.size() > 0;
            ex_pc     = ex_valid ? mq[0].pc : 32'h0;
            ex_bundle = ex_valid ? mq[0].bundle : '0;
            ex_occ    = 3'(mq.size());
            ex_done   = (m_fetch_pc >= dsa_next) && mq.size() == 0 && !m_pend;
        end

        check_eq("mem_req_valid", mem_req_valid, ex_req);
        if (ex_req) check_eq("mem_req_pc", mem_req_pc, m_fetch_pc);
        check_eq("out_valid", out_valid, ex_valid);
        check_eq("out_pc", out_pc, ex_pc);
        check_eq("out_bundle", out_bundle, ex_bundle);
        check_eq("occupancy", occupancy, ex_occ);
        check_eq("fetch_done", fetch_done, ex_done);
`ifdef BPQ_STATS_EN
        check_eq("stat_empty_cycles", stat_empty_cycles, m_empty_cnt);
        check_eq("stat_flushes", stat_flushes, m_flush_cnt);
`endif

        last_req = mem_req_valid;
        last_pc  = mem_req_pc;

        if (r) begin
            model_reset();
        end else begin
            if (mq.size() == 0 && !ex_done && m_empty_cnt != 32'hFFFF_FFFF) m_empty_cnt++;
            if (fl && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
            if (fl) begin
                mq.delete();
                m_pend     = 1'b0;
                m_fetch_pc = fpc;
            end else begin
                if (ex_valid && rdy) void'(mq.pop_front());
                if (mem_rsp_valid && m_pend) begin
                    e.pc     = m_pend_pc;
                    e.bundle = mem_rsp_bundle;
                    mq.push_back(e);
                end
                if (ex_req) begin
                    m_pend     = 1'b1;
                    m_pend_pc  = m_fetch_pc;
                    m_fetch_pc = m_fetch_pc + 32'd16;
                end else if (mem_rsp_valid && m_pend) begin
                    m_pend = 1'b0;
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_pc(input int max_bundles);
        return 32'($urandom_range(0, max_bundles)) << 4;
    endfunction

    initial begin
        rst             = 1'b1;
        out_ready       = 1'b1;
        flush           = 1'b0;
        flush_pc        = 32'h0;
        mem_rsp_valid   = 1'b0;
        mem_rsp_bundle  = '0;
        data_start_addr = 32'h100;
        dsa_next        = 32'h100;
        last_req        = 1'b0;
        last_pc         = 32'h0;
        model_reset();

        // Streaming fetch with a consumer that never stalls.
        repeat (2) step(1, 1, 0, 0);
        repeat (40) step(0, 1, 0, 0);

        // Stalled consumer: queue fills to DEPTH, issue stops until the first pop.
        repeat (2) step(1, 0, 0, 0);
        repeat (12) step(0, 0, 0, 0);
        check_eq("occupancy_full", occupancy, 3'd4);
        repeat (10) step(0, 1, 0, 0);

        // Flush with a partly filled queue and a request in flight.
        repeat (2) step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h80);
        repeat (12) step(0, 1, 0, 0);

        // Boundary at 0x30: only three bundles, then fetch_done holds.
        dsa_next = 32'h30;
        repeat (2) step(1, 1, 0, 0);
        repeat (20) step(0, 1, 0, 0);
        check_eq("fetch_done_hold", fetch_done, 1'b1);
        // Flush below the boundary re-enables fetch.
        step(0, 1, 1, 32'h10);
        repeat (8) step(0, 1, 0, 0);

        // Full queue with flush and pop in the same cycle.
        dsa_next = 32'h100;
        repeat (2) step(1, 0, 0, 0);
        repeat (8) step(0, 0, 0, 0);
        step(0, 1, 1, 32'h40);
        repeat (10) step(0, 1, 0, 0);

        // Randomised traffic: stalls, flushes, moving boundary, occasional reset.
        repeat (2) step(1, 1, 0, 0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) dsa_next = rand_pc(48);
            step($urandom_range(0, 79) == 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 15) == 0,
                 rand_pc(40));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
